// File: rtl/pim_pkg.sv
// Shared types for the PIM arbiter/scheduler: MAC sequencer states and grant select.
package pim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    MAC  = 2'd3
  } grant_e;

endpackage

// File: rtl/pim_prio_arb.sv
// Single-grant priority arbiter: write > read > MAC beat, unless the MAC beat is forced.
module pim_prio_arb
  import pim_pkg::*;
(
  input  logic   wr_req_i,
  input  logic   rd_req_i,
  input  logic   mac_req_i,
  input  logic   mac_force_i,
  output grant_e grant_o
);

  always_comb begin
    grant_o = NONE;
    if (mac_req_i && mac_force_i) begin
      grant_o = MAC;
    end else if (wr_req_i) begin
      grant_o = WR;
    end else if (rd_req_i) begin
      grant_o = RD;
    end else if (mac_req_i) begin
      grant_o = MAC;
    end
  end

endmodule

// File: rtl/pim_arb_sched.sv
// PIM array front end: arbitrates write, read and MAC-job beats onto one array port.
// Define PIM_ARB_SCHED_STARVE_EN to force a MAC beat after STARVE_LIMIT unserved RUN cycles.
module pim_arb_sched
  import pim_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 14,
  parameter int LEN_WIDTH    = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_valid,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic                  rd_data_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  mac_start,
  input  logic [ADDR_WIDTH-1:0] mac_addr,
  input  logic [LEN_WIDTH-1:0]  mac_len,
  output logic                  mac_busy,
  output logic                  mac_done,
  output logic [DATA_WIDTH-1:0] mac_result,
  output logic [ADDR_WIDTH-1:0] pim_addr,
  output logic [DATA_WIDTH-1:0] pim_d,
  output logic                  pim_w_en,
  output logic                  pim_p_en,
  input  logic [DATA_WIDTH-1:0] pim_q,
  input  logic [DATA_WIDTH-1:0] pim_mac_out
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  rd_vld_q;
  grant_e                grant;
  logic                  mac_force;

`ifdef PIM_ARB_SCHED_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;

  // Counts consecutive unserved RUN cycles; saturates at the limit until a beat is granted.
  always_comb begin
    starve_d = '0;
    if (state_q == RUN && grant != MAC) begin
      starve_d = (starve_q >= SW'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end

  assign mac_force = (state_q == RUN) && (starve_q >= SW'(STARVE_LIMIT));
`else
  assign mac_force = 1'b0;
`endif

  pim_prio_arb u_arb (
    .wr_req_i    (wr_valid),
    .rd_req_i    (rd_valid),
    .mac_req_i   (state_q == RUN),
    .mac_force_i (mac_force),
    .grant_o     (grant)
  );

  assign wr_ready = (grant == WR);
  assign rd_ready = (grant == RD);

  always_comb begin
    pim_addr = '0;
    pim_d    = '0;
    pim_w_en = 1'b0;
    pim_p_en = 1'b0;
    case (grant)
      WR: begin
        pim_addr = wr_addr;
        pim_d    = wr_data;
        pim_w_en = 1'b1;
      end
      RD:  pim_addr = rd_addr;
      MAC: begin
        pim_addr = ptr_q;
        pim_p_en = 1'b1;
      end
      default: ;
    endcase
  end

  // A zero count on a granted beat means that beat was the last one of the job.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (mac_start) begin
          ptr_d   = mac_addr;
          cnt_d   = mac_len;
          state_d = RUN;
        end
      end
      RUN: begin
        if (grant == MAC) begin
          ptr_d = ptr_q + 1'b1;
          if (cnt_q == '0) state_d = DRAIN;
          else             cnt_d = cnt_q - 1'b1;
        end
      end
      DRAIN: begin
        result_d = pim_mac_out;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      rd_vld_q <= (grant == RD);
    end
  end

  assign mac_busy      = (state_q != IDLE);
  assign mac_done      = done_q;
  assign mac_result    = result_q;
  assign rd_data_valid = rd_vld_q;
  assign rd_data       = pim_q;

endmodule

// File: tb/tb_pim_arb_sched.sv
// Scoreboard bench for pim_arb_sched with a behavioural PIM array and reference model.
// Honours PIM_ARB_SCHED_STARVE_EN to select the starvation-forcing expectations.
module tb_pim_arb_sched;

  localparam int DW = 32;
  localparam int AW = 14;
  localparam int LW = 8;
  localparam int SL = 8;
`ifdef PIM_ARB_SCHED_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wrValid = 1'b0;
  logic [AW-1:0] wrAddr = '0;
  logic [DW-1:0] wrData = '0;
  logic          wrReady;
  logic          rdValid = 1'b0;
  logic [AW-1:0] rdAddr = '0;
  logic          rdReady;
  logic          rdDataValid;
  logic [DW-1:0] rdData;
  logic          macStart = 1'b0;
  logic [AW-1:0] macAddr = '0;
  logic [LW-1:0] macLen = '0;
  logic          macBusy;
  logic          macDone;
  logic [DW-1:0] macResult;
  logic [AW-1:0] pimAddr;
  logic [DW-1:0] pimD;
  logic          pimWEn;
  logic          pimPEn;
  logic [DW-1:0] pimQ = '0;
  logic [DW-1:0] pimAcc = '0;

  int total = 0;
  int bad = 0;

  pim_arb_sched #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wrValid), .wr_addr(wrAddr), .wr_data(wrData), .wr_ready(wrReady),
    .rd_valid(rdValid), .rd_addr(rdAddr), .rd_ready(rdReady),
    .rd_data_valid(rdDataValid), .rd_data(rdData),
    .mac_start(macStart), .mac_addr(macAddr), .mac_len(macLen),
    .mac_busy(macBusy), .mac_done(macDone), .mac_result(macResult),
    .pim_addr(pimAddr), .pim_d(pimD), .pim_w_en(pimWEn), .pim_p_en(pimPEn),
    .pim_q(pimQ), .pim_mac_out(pimAcc)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] initVal(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // PIM array: synchronous read, MAC accumulator cleared when a job is accepted.
  bit [DW-1:0] pimMem [16384];
  bit          pimWr  [16384];

  function automatic logic [DW-1:0] pimRead(input logic [AW-1:0] a);
    return pimWr[a] ? pimMem[a] : initVal(a);
  endfunction

  always @(posedge clk) begin
    if (pimWEn) begin
      pimMem[pimAddr] <= pimD;
      pimWr[pimAddr]  <= 1'b1;
    end
    pimQ <= pimRead(pimAddr);
    if (macStart && !macBusy) pimAcc <= '0;
    else if (pimPEn)          pimAcc <= pimAcc + pimRead(pimAddr);
  end

  // Reference memory, expectation queues and starvation bookkeeping.
  bit [DW-1:0]   refMem [16384];
  bit            refWr  [16384];
  logic [AW-1:0] beatQ [$];
  logic [DW-1:0] rdQ [$];
  logic [DW-1:0] resQ [$];
  int            waitCnt = 0;
  logic [AW-1:0] pushA;
  logic [DW-1:0] pushSum;
  logic [DW-1:0] popV;
  logic [AW-1:0] popA;
  logic          macReq, forced, expWr, expRd, expMac;
  logic [AW-1:0] addrTab [4] = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
  int            beatPos [$];

  function automatic logic [DW-1:0] refRead(input logic [AW-1:0] a);
    return refWr[a] ? refMem[a] : initVal(a);
  endfunction

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input bit rv, input logic [AW-1:0] ra,
                               input bit ms, input logic [AW-1:0] ma, input logic [LW-1:0] ml);
    wrValid = wv; wrAddr = wa; wrData = wd;
    rdValid = rv; rdAddr = ra;
    macStart = ms; macAddr = ma; macLen = ml;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDone(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      #2;
      if (macDone) seen = 1'b1;
      step();
    end
  endtask

  // Stimulus side: accepted requests push their expected responses.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (wrValid && wrReady) begin
        refMem[wrAddr] = wrData;
        refWr[wrAddr]  = 1'b1;
      end
      if (!rst_n) begin
        beatQ.delete();
        resQ.delete();
      end else begin
        if (rdValid && rdReady) rdQ.push_back(refRead(rdAddr));
        if (macStart && resQ.size() == 0) begin
          pushSum = '0;
          for (int i = 0; i <= int'(macLen); i++) begin
            pushA = macAddr + AW'(i);
            beatQ.push_back(pushA);
            pushSum = pushSum + refRead(pushA);
          end
          resQ.push_back(pushSum);
        end
      end
    end
  end

  // Monitor: grant legality, beat order, read returns and job results.
  initial begin
    forever begin
      @(negedge clk);
      macReq = (beatQ.size() > 0);
      forced = STARVE && macReq && (waitCnt >= SL);
      expWr  = wrValid && !forced;
      expRd  = rdValid && !wrValid && !forced;
      expMac = macReq && (forced || (!wrValid && !rdValid));
      checkOutput("wr_ready", 32'(wrReady), 32'(expWr));
      checkOutput("rd_ready", 32'(rdReady), 32'(expRd));
      checkOutput("pim_w_en", 32'(pimWEn), 32'(expWr));
      checkOutput("pim_p_en", 32'(pimPEn), 32'(expMac));
      if (expWr) begin
        checkOutput("wr_pim_addr", 32'(pimAddr), 32'(wrAddr));
        checkOutput("wr_pim_d", pimD, wrData);
      end else if (expRd) begin
        checkOutput("rd_pim_addr", 32'(pimAddr), 32'(rdAddr));
      end else if (expMac) begin
        popA = beatQ.pop_front();
        checkOutput("beat_addr", 32'(pimAddr), 32'(popA));
      end else begin
        checkOutput("idle_pim_addr", 32'(pimAddr), 32'd0);
        checkOutput("idle_pim_d", pimD, 32'd0);
      end
      if (!rst_n || beatQ.size() == 0 || expMac) waitCnt = 0;
      else                                        waitCnt++;

      checkOutput("rd_data_valid", 32'(rdDataValid), 32'(rdQ.size() > 0));
      if (rdDataValid && rdQ.size() > 0) begin
        popV = rdQ.pop_front();
        checkOutput("rd_data", rdData, popV);
      end

      if (macDone) begin
        if (resQ.size() == 0 || beatQ.size() != 0) begin
          total++;
          bad++;
          $display("[TB] FAIL mac_done_unexpected: got 1 want 0 at %0t", $time);
        end else begin
          popV = resQ.pop_front();
          checkOutput("mac_result", macResult, popV);
        end
      end
      checkOutput("mac_busy", 32'(macBusy), 32'(resQ.size() > 0));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    int cnt;
    idle();
    rst_n = 1'b0;
    repeat (3) step();
    #1;
    checkOutput("rst_mac_busy", 32'(macBusy), 32'd0);
    checkOutput("rst_mac_done", 32'(macDone), 32'd0);
    checkOutput("rst_rd_data_valid", 32'(rdDataValid), 32'd0);
    checkOutput("rst_mac_result", macResult, 32'd0);
    checkOutput("rst_pim_p_en", 32'(pimPEn), 32'd0);
    checkOutput("rst_pim_w_en", 32'(pimWEn), 32'd0);
    rst_n = 1'b1;
    step();

    $display("[TB] single write");
    applyStimulus(1'b1, 14'd5, 32'hA5A5A5A5, 1'b0, '0, 1'b0, '0, '0);
    #2;
    checkOutput("w_pim_w_en", 32'(pimWEn), 32'd1);
    checkOutput("w_pim_addr", 32'(pimAddr), 32'd5);
    checkOutput("w_wr_ready", 32'(wrReady), 32'd1);
    checkOutput("w_pim_d", pimD, 32'hA5A5A5A5);
    step();

    $display("[TB] write and read collide");
    applyStimulus(1'b1, 14'h120, 32'hC0FFEE01, 1'b1, 14'h120, 1'b0, '0, '0);
    #2;
    checkOutput("c_wr_first", 32'(wrReady), 32'd1);
    checkOutput("c_rd_waits", 32'(rdReady), 32'd0);
    step();
    applyStimulus(1'b0, '0, '0, 1'b1, 14'h120, 1'b0, '0, '0);
    #2;
    checkOutput("c_rd_second", 32'(rdReady), 32'd1);
    checkOutput("c_rd_addr", 32'(pimAddr), 32'h120);
    step();
    idle();
    #2;
    checkOutput("c_rd_valid", 32'(rdDataValid), 32'd1);
    checkOutput("c_rd_data", rdData, 32'hC0FFEE01);
    step();
    #2;
    checkOutput("c_rd_valid_once", 32'(rdDataValid), 32'd0);
    step();

    $display("[TB] wrapping MAC job");
    pushSum = refRead(14'h3FFE) + refRead(14'h3FFF) + refRead(14'h0000) + refRead(14'h0001);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 14'h3FFE, 8'd3);
    step();
    idle();
    for (int i = 0; i < 8; i++) begin
      #2;
      checkOutput($sformatf("wrap_p_en_%0d", i), 32'(pimPEn), 32'(i < 4));
      if (i < 4) checkOutput($sformatf("wrap_addr_%0d", i), 32'(pimAddr), 32'(addrTab[i]));
      checkOutput($sformatf("wrap_done_%0d", i), 32'(macDone), 32'(i == 5));
      if (i == 5) checkOutput("wrap_result", macResult, pushSum);
      step();
    end

    $display("[TB] MAC under continuous writes");
    applyStimulus(1'b1, 14'h150, 32'h0BAD0BAD, 1'b0, '0, 1'b1, 14'h3F20, 8'd2);
    step();
    applyStimulus(1'b1, 14'h150, 32'h0BAD0BAD, 1'b0, '0, 1'b0, '0, '0);
    beatPos.delete();
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #2;
      if (pimPEn) beatPos.push_back(i);
      if (macDone) seen = 1'b1;
      step();
    end
`ifdef PIM_ARB_SCHED_STARVE_EN
    checkOutput("starve_beats", 32'(beatPos.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("starve_pos_%0d", k),
                  32'((k < beatPos.size()) ? beatPos[k] : -1), 32'(8 + 9 * k));
    end
`else
    checkOutput("fixed_no_beats", 32'(beatPos.size()), 32'd0);
`endif
    idle();
    if (!seen) waitDone(20, seen);
    checkOutput("starve_job_done", 32'(seen), 32'd1);
    step();

    $display("[TB] reset mid job");
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 14'h3F30, 8'd4);
    step();
    idle();
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 2; i++) begin
      #2;
      if (pimPEn) cnt++;
      step();
    end
    checkOutput("pre_reset_beats", 32'(cnt), 32'd2);
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b1, 14'h130, 1'b0, '0, '0);
    step();
    rst_n = 1'b1;
    idle();
    #2;
    checkOutput("post_reset_busy", 32'(macBusy), 32'd0);
    checkOutput("post_reset_no_rd", 32'(rdDataValid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      #2;
      checkOutput("post_reset_no_done", 32'(macDone), 32'd0);
      step();
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 14'h3F10, 8'd1);
    step();
    idle();
    waitDone(20, seen);
    checkOutput("fresh_job_done", 32'(seen), 32'd1);

    $display("[TB] start while busy");
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 14'h3F40, 8'd5);
    step();
    cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 14'h3F80, 8'd1);
      else        idle();
      #2;
      if (pimPEn) cnt++;
      if (i == 2) checkOutput("busy_ptr_kept", 32'(pimAddr), 32'h3F42);
      if (macDone) seen = 1'b1;
      step();
    end
    checkOutput("busy_beat_count", 32'(cnt), 32'd6);
    checkOutput("busy_job_done", 32'(seen), 32'd1);

    $display("[TB] random traffic");
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(3, 0) == 0), AW'(32'h100 + $urandom_range(255, 0)), $urandom,
                    ($urandom_range(2, 0) == 0), AW'($urandom_range(511, 0)),
                    ($urandom_range(11, 0) == 0), AW'(32'h3F00 + $urandom_range(255, 0)),
                    LW'($urandom_range(15, 0)));
      step();
    end
    idle();
    for (int i = 0; i < 300 && (beatQ.size() + resQ.size() + rdQ.size()) != 0; i++) step();
    step();
    checkOutput("drain_beats", 32'(beatQ.size()), 32'd0);
    checkOutput("drain_results", 32'(resQ.size()), 32'd0);
    checkOutput("drain_reads", 32'(rdQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pim_arb_sched.md
PIM_ARB_SCHED -- requirements
Module: pim_arb_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the PIM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 14, the PIM word-address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 8, the MAC job length-field width.
REQ-004 SHALL have parameter STARVE_LIMIT, default 8, the cycles a pending MAC beat waits before forced grant.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, the reset; synchronous, active-low.
REQ-007 SHALL have ports wr_valid (input, 1), wr_addr (input, ADDR_WIDTH), wr_data (input, DATA_WIDTH) and wr_ready (output, 1), the write requester.
REQ-008 SHALL have ports rd_valid (input, 1), rd_addr (input, ADDR_WIDTH), rd_ready (output, 1), rd_data_valid (output, 1) and rd_data (output, DATA_WIDTH), the read requester.
REQ-009 SHALL have ports mac_start (input, 1), mac_addr (input, ADDR_WIDTH), mac_len (input, LEN_WIDTH), mac_busy (output, 1), mac_done (output, 1) and mac_result (output, DATA_WIDTH), the MAC job port.
REQ-010 SHALL have ports pim_addr (output, ADDR_WIDTH), pim_d (output, DATA_WIDTH), pim_w_en (output, 1), pim_p_en (output, 1), pim_q (input, DATA_WIDTH) and pim_mac_out (input, DATA_WIDTH), the PIM array port.

Function
REQ-011 SHALL grant at most one of write, read or MAC beat per cycle; wr_ready, rd_ready and pim_w_en/pim_p_en are combinational from the grant.
REQ-012 SHALL use fixed priority write > read > MAC beat, except as modified by REQ-025.
REQ-013 SHALL, on a write grant, drive pim_addr=wr_addr, pim_d=wr_data, pim_w_en=1, with the transfer completing when wr_valid&&wr_ready.
REQ-014 SHALL, on a read grant, drive pim_addr=rd_addr with pim_w_en=0; one cycle later set rd_data_valid=1 for exactly one cycle and rd_data=pim_q; there is no back-pressure on read data.
REQ-015 SHALL, when not busy, on mac_start: latch mac_addr into the pointer, latch mac_len into the beat counter, set mac_busy=1 and enter the RUN state; a mac_start while busy SHALL be ignored.
REQ-016 SHALL, in the RUN state, on each MAC-beat grant drive pim_addr=pointer and pim_p_en=1, increment the pointer modulo 2^ADDR_WIDTH and decrement the counter.
REQ-017 SHALL issue mac_len+1 beats in total (mac_len=0 gives one beat), then enter the DRAIN state.
REQ-018 SHALL, in the DRAIN state, wait one cycle, then capture pim_mac_out into mac_result, pulse mac_done for one cycle, clear mac_busy and return to IDLE.
REQ-019 SHALL allow a new mac_start to be accepted in the cycle after mac_done.
REQ-020 SHALL hold mac_result until the next mac_done.
REQ-021 SHALL drive pim_w_en=0, pim_p_en=0, pim_addr=0 and pim_d=0 in cycles with no grant.
REQ-022 SHALL have states IDLE, RUN and DRAIN only.

Reset
REQ-023 SHALL, while rst_n=0 at a clock edge, force: state IDLE; mac_busy, mac_done and rd_data_valid to 0; mac_result, pointer, counter and starvation counter to 0.
REQ-024 SHALL abort any in-flight MAC job on reset mid-job without asserting mac_done; a read grant issued in the reset cycle SHALL produce no rd_data_valid.

Configuration
REQ-025 SHALL, with macro PIM_ARB_SCHED_STARVE_EN defined, count the consecutive cycles in RUN without a MAC grant; when the count reaches STARVE_LIMIT, the MAC beat wins the next cycle over write and read, and the counter resets on any MAC grant.
REQ-026 SHALL, without PIM_ARB_SCHED_STARVE_EN, use pure fixed priority and contain no starvation counter.

Structure
REQ-027 SHALL place the state encoding (IDLE/RUN/DRAIN) and the grant-select enum (NONE/WR/RD/MAC) in the shared package pim_pkg.
REQ-028 SHALL implement the grant logic as sub-module pim_prio_arb; the MAC sequencer and read-return pipeline SHALL stay in the top level.

Verification
REQ-029 SHALL cover: wr_valid=1, addr=5, data=0xA5A5A5A5, idle otherwise -> the same cycle shows pim_w_en=1, pim_addr=5, wr_ready=1.
REQ-030 SHALL cover: wr_valid and rd_valid asserted together for 1 cycle -> write granted first, read granted the next cycle, rd_data_valid the cycle after that.
REQ-031 SHALL cover: mac_start with addr=0x3FFE, len=3, no other traffic -> pim_p_en on 4 consecutive cycles at addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001; mac_done 2 cycles after the last beat; mac_result=pim_mac_out.
REQ-032 SHALL cover: continuous wr_valid during a MAC job with STARVE_EN and STARVE_LIMIT=8 -> one MAC beat every 9th cycle and job completion; without the macro -> no MAC beat while wr_valid stays high.
REQ-033 SHALL cover: rst_n=0 for 1 cycle mid-job at beat 2 of 5 -> mac_busy=0 and no mac_done, then a fresh job completes normally.
REQ-034 SHALL cover: mac_start pulsed while mac_busy=1 -> ignored, with pointer and count unchanged.
